// File: rtl/sm_phase_decoder.sv
// sm_phase_decoder
// Monitors the four one-hot wave-drive coil lines of a stepper motor and
// rebuilds the drive's phase, step events and direction. It keeps a wrapping
// position count and a saturating step-period measurement. It also reports
// coil patterns that are not legal, and phase jumps of two positions.
//
// Coil bit order inside this block: bit0=A1 (phase 0), bit1=B1 (phase 1),
// bit2=A2 (phase 2), bit3=B2 (phase 3). A forward step is phase+1 mod 4.
module sm_phase_decoder #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int POS_W         = 16,
    parameter int PER_W         = 24
) (
    input  logic             CLK,
    input  logic             rstn,
    input  logic             A1,
    input  logic             B1,
    input  logic             A2,
    input  logic             B2,
    input  logic             pos_clr,
    output logic [1:0]       phase,
    output logic             phase_valid,
    output logic             step_pulse,
    output logic             dir,
    output logic [POS_W-1:0] pos,
    output logic [PER_W-1:0] period,
    output logic             err_skip,
    output logic             err_pattern
);

    // The stability counter only has to reach STABLE_CYCLES-1; keep it at
    // least one bit wide so that STABLE_CYCLES=1 still elaborates.
    localparam int SCNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [SCNT_W-1:0] SCNT_MAX = SCNT_W'(STABLE_CYCLES - 1);
    localparam logic [PER_W-1:0]  PCNT_MAX = '1;

    logic [3:0]                   coil_raw;
    logic [SYNC_STAGES-1:0][3:0]  sync_q;
    logic [3:0]                   sync_out;

    logic [3:0]        cand;
    logic [SCNT_W-1:0] scnt;
    logic [3:0]        acc_pat;
    logic              accept;

    logic              pat_onehot;
    logic              pat_idle;
    logic [1:0]        new_idx;
    logic [1:0]        delta;
    logic              valid_acc;
    logic              do_fwd;
    logic              do_rev;
    logic              do_skip;
    logic              do_step;
    logic              bad_pat;

    logic [PER_W-1:0]  pcnt;

    assign coil_raw = {B2, A2, B1, A1};
    assign sync_out = sync_q[SYNC_STAGES-1];

    // Bring the asynchronous coil lines into the CLK domain through a plain
    // shift-register synchronizer.
    always_ff @(posedge CLK or negedge rstn) begin
        if (!rstn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], coil_raw};
        end
    end

    // A new pattern becomes the candidate and must then stay unchanged for
    // STABLE_CYCLES samples; the counter saturates so a long-held pattern
    // remains eligible, while acc_pat stops it being accepted twice.
    always_ff @(posedge CLK or negedge rstn) begin
        if (!rstn) begin
            cand    <= '0;
            scnt    <= '0;
            acc_pat <= '0;
        end else begin
            if (sync_out != cand) begin
                cand <= sync_out;
                scnt <= '0;
            end else if (scnt != SCNT_MAX) begin
                scnt <= scnt + SCNT_W'(1);
            end
            if (accept) begin
                acc_pat <= cand;
            end
        end
    end

    assign accept = (scnt == SCNT_MAX) && (cand != acc_pat);

    // Classify the candidate pattern and work out how far the phase moved
    // relative to the last valid phase.
    always_comb begin
        new_idx    = 2'd0;
        pat_onehot = 1'b0;
        case (cand)
            4'b0001: begin new_idx = 2'd0; pat_onehot = 1'b1; end
            4'b0010: begin new_idx = 2'd1; pat_onehot = 1'b1; end
            4'b0100: begin new_idx = 2'd2; pat_onehot = 1'b1; end
            4'b1000: begin new_idx = 2'd3; pat_onehot = 1'b1; end
            default: begin new_idx = 2'd0; pat_onehot = 1'b0; end
        endcase
        pat_idle  = (cand == 4'b0000);
        delta     = new_idx - phase;
        valid_acc = accept && pat_onehot;
        do_fwd    = valid_acc && phase_valid && (delta == 2'd1);
        do_rev    = valid_acc && phase_valid && (delta == 2'd3);
        do_skip   = valid_acc && phase_valid && (delta == 2'd2);
        do_step   = do_fwd || do_rev;
        bad_pat   = accept && !pat_onehot && !pat_idle;
    end

    // Register the decoded phase, the single-cycle event pulses, direction,
    // the position count (a clear request beats a simultaneous step) and the
    // period captured on each step.
    always_ff @(posedge CLK or negedge rstn) begin
        if (!rstn) begin
            phase       <= 2'd0;
            phase_valid <= 1'b0;
            step_pulse  <= 1'b0;
            dir         <= 1'b0;
            pos         <= '0;
            period      <= '0;
            err_skip    <= 1'b0;
            err_pattern <= 1'b0;
        end else begin
            step_pulse  <= do_step;
            err_skip    <= do_skip;
            err_pattern <= bad_pat;
            if (valid_acc) begin
                phase       <= new_idx;
                phase_valid <= 1'b1;
            end
            if (do_step) begin
                dir    <= do_fwd;
                period <= pcnt;
            end
            if (pos_clr) begin
                pos <= '0;
            end else if (do_fwd) begin
                pos <= pos + POS_W'(1);
            end else if (do_rev) begin
                pos <= pos - POS_W'(1);
            end
        end
    end

    // Free-running step-period counter: it restarts at 1 on every real step
    // (a skip is not a step) and sticks at all-ones when the motor stalls.
    always_ff @(posedge CLK or negedge rstn) begin
        if (!rstn) begin
            pcnt <= '0;
        end else if (do_step) begin
            pcnt <= PER_W'(1);
        end else if (pcnt != PCNT_MAX) begin
            pcnt <= pcnt + PER_W'(1);
        end
    end

endmodule

// File: tb/tb_sm_phase_decoder.sv
// tb_sm_phase_decoder
// Directed bench for the coil phase decoder. A window-based behavioural model
// predicts every output on every clock, and hand-computed literals pin the
// model at the end of each scenario. A second instance with a one-clock
// stability filter is stepped quickly to reach the 0x7FFF -> 0x8000 wrap.
`timescale 1ns/1ps
module tb_sm_phase_decoder;

    localparam int SYNC = 2;
    localparam int STAB = 4;
    localparam int HLEN = SYNC + 1 + STAB;
    localparam int PMAX = (1 << 24) - 1;

    logic        CLK = 1'b0;
    logic        rstn = 1'b0;
    logic        A1 = 1'b0, B1 = 1'b0, A2 = 1'b0, B2 = 1'b0;
    logic        pos_clr = 1'b0;
    logic [1:0]  phase;
    logic        phase_valid, step_pulse, dir, err_skip, err_pattern;
    logic [15:0] pos;
    logic [23:0] period;

    logic [3:0]  c2 = 4'b0000;
    logic [1:0]  phase2;
    logic        phase_valid2, step_pulse2, dir2, err_skip2, err_pattern2;
    logic [15:0] pos2;
    logic [23:0] period2;

    int total = 0;
    int bad   = 0;
    int n_step = 0, n_skip = 0, n_pat = 0, n_step2 = 0;
    int base;

    // Model state
    logic [3:0] hist[$];
    logic [3:0] m_acc;
    int         m_phase, m_valid, m_dir, m_pos, m_period, m_cnt;
    logic       e_step, e_skip, e_pat;

    sm_phase_decoder #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(STAB), .POS_W(16), .PER_W(24)) dut (
        .CLK(CLK), .rstn(rstn), .A1(A1), .B1(B1), .A2(A2), .B2(B2), .pos_clr(pos_clr),
        .phase(phase), .phase_valid(phase_valid), .step_pulse(step_pulse), .dir(dir),
        .pos(pos), .period(period), .err_skip(err_skip), .err_pattern(err_pattern)
    );

    sm_phase_decoder #(.SYNC_STAGES(2), .STABLE_CYCLES(1), .POS_W(16), .PER_W(24)) dut_fast (
        .CLK(CLK), .rstn(rstn), .A1(c2[0]), .B1(c2[1]), .A2(c2[2]), .B2(c2[3]), .pos_clr(1'b0),
        .phase(phase2), .phase_valid(phase_valid2), .step_pulse(step_pulse2), .dir(dir2),
        .pos(pos2), .period(period2), .err_skip(err_skip2), .err_pattern(err_pattern2)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] pat, input int clocks);
        {B2, A2, B1, A1} = pat;
        repeat (clocks) @(negedge CLK);
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < HLEN; i++) hist.push_back(4'b0000);
        m_acc = 4'b0000;
        m_phase = 0; m_valid = 0; m_dir = 0; m_pos = 0; m_period = 0; m_cnt = 0;
        e_step = 1'b0; e_skip = 1'b0; e_pat = 1'b0;
    endtask

    // A pattern is accepted when the STAB oldest samples of the last HLEN
    // all agree and differ from the last accepted pattern.
    task automatic model_advance(input logic [3:0] s, input logic clr);
        logic [3:0] w;
        bit         stable;
        int         idx, d, stp;
        hist.push_back(s);
        if (hist.size() > HLEN) void'(hist.pop_front());
        e_step = 1'b0; e_skip = 1'b0; e_pat = 1'b0;
        stp = 0;
        w = hist[0];
        stable = 1'b1;
        for (int i = 0; i < STAB; i++) if (hist[i] != w) stable = 1'b0;
        if (stable && (w != m_acc)) begin
            m_acc = w;
            if (w == 4'b0000) begin
            end else if ($countones(w) != 1) begin
                e_pat = 1'b1;
            end else begin
                idx = 0;
                for (int i = 0; i < 4; i++) if (w[i]) idx = i;
                if (m_valid == 0) begin
                    m_valid = 1;
                end else begin
                    d = (idx - m_phase + 4) % 4;
                    if (d == 1) begin e_step = 1'b1; m_dir = 1; stp = 1; end
                    else if (d == 3) begin e_step = 1'b1; m_dir = 0; stp = -1; end
                    else if (d == 2) e_skip = 1'b1;
                end
                m_phase = idx;
            end
        end
        if (e_step) begin
            m_period = m_cnt;
            m_cnt = 1;
        end else if (m_cnt < PMAX) begin
            m_cnt++;
        end
        if (clr) m_pos = 0;
        else m_pos = (m_pos + stp + 65536) % 65536;
    endtask

    // Advance the model on every active edge and compare shortly after it.
    always begin
        @(posedge CLK);
        if (!rstn) model_reset();
        else model_advance({B2, A2, B1, A1}, pos_clr);
        #1;
        checkOutput("cyc_phase",       32'(phase),       32'(m_phase));
        checkOutput("cyc_phase_valid", 32'(phase_valid), 32'(m_valid));
        checkOutput("cyc_step_pulse",  32'(step_pulse),  32'(e_step));
        checkOutput("cyc_dir",         32'(dir),         32'(m_dir));
        checkOutput("cyc_pos",         32'(pos),         32'(m_pos));
        checkOutput("cyc_period",      32'(period),      32'(m_period));
        checkOutput("cyc_err_skip",    32'(err_skip),    32'(e_skip));
        checkOutput("cyc_err_pattern", 32'(err_pattern), 32'(e_pat));
        if (step_pulse)  n_step++;
        if (err_skip)    n_skip++;
        if (err_pattern) n_pat++;
        if (step_pulse2) n_step2++;
    end

    // Watchdog so the run always ends even if the stimulus stalls.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios.
    initial begin
        applyStimulus(4'b0000, 3);
        rstn = 1'b1;

        $display("[TB] T1 first phase");
        applyStimulus(4'b0001, 10);
        checkOutput("t1_phase", 32'(phase), 32'd0);
        checkOutput("t1_valid", 32'(phase_valid), 32'd1);
        checkOutput("t1_pos", 32'(pos), 32'd0);
        checkOutput("t1_steps", 32'(n_step), 32'd0);

        $display("[TB] T2 forward");
        applyStimulus(4'b0010, 20);
        applyStimulus(4'b0100, 20);
        applyStimulus(4'b1000, 20);
        applyStimulus(4'b0001, 20);
        checkOutput("t2_steps", 32'(n_step), 32'd4);
        checkOutput("t2_dir", 32'(dir), 32'd1);
        checkOutput("t2_pos", 32'(pos), 32'd4);
        checkOutput("t2_period", 32'(period), 32'd20);
        checkOutput("t2_phase", 32'(phase), 32'd0);

        @(negedge CLK); pos_clr = 1'b1;
        @(negedge CLK); pos_clr = 1'b0;
        checkOutput("clr_pos", 32'(pos), 32'd0);

        $display("[TB] T3 reverse");
        base = n_step;
        applyStimulus(4'b1000, 20);
        applyStimulus(4'b0100, 20);
        applyStimulus(4'b0010, 20);
        checkOutput("t3_steps", 32'(n_step - base), 32'd3);
        checkOutput("t3_dir", 32'(dir), 32'd0);
        checkOutput("t3_pos", 32'(pos), 32'h0000FFFD);
        checkOutput("t3_phase", 32'(phase), 32'd1);
        checkOutput("t3_period", 32'(period), 32'd20);

        $display("[TB] T4 skip and bad pattern");
        applyStimulus(4'b0001, 20);
        checkOutput("t4_pos_a", 32'(pos), 32'h0000FFFC);
        applyStimulus(4'b0100, 20);
        checkOutput("t4_skips", 32'(n_skip), 32'd1);
        checkOutput("t4_pos_b", 32'(pos), 32'h0000FFFC);
        checkOutput("t4_phase_b", 32'(phase), 32'd2);
        checkOutput("t4_period", 32'(period), 32'd20);
        applyStimulus(4'b0011, 20);
        checkOutput("t4_pats", 32'(n_pat), 32'd1);
        checkOutput("t4_phase_c", 32'(phase), 32'd2);
        base = n_step;
        applyStimulus(4'b0100, 20);
        checkOutput("t4_nostep", 32'(n_step - base), 32'd0);

        $display("[TB] T5 glitch, clear with step, idle");
        applyStimulus(4'b1000, 20);
        applyStimulus(4'b0001, 20);
        checkOutput("t5_pos_a", 32'(pos), 32'h0000FFFE);
        base = n_step;
        applyStimulus(4'b0010, 2);
        applyStimulus(4'b0001, 20);
        checkOutput("t5_glitch_steps", 32'(n_step - base), 32'd0);
        checkOutput("t5_glitch_skips", 32'(n_skip), 32'd1);
        checkOutput("t5_glitch_pats", 32'(n_pat), 32'd1);
        checkOutput("t5_glitch_phase", 32'(phase), 32'd0);
        applyStimulus(4'b0010, 6);
        checkOutput("t5_lat6", 32'(step_pulse), 32'd0);
        pos_clr = 1'b1;
        @(negedge CLK);
        pos_clr = 1'b0;
        checkOutput("t5_lat7", 32'(step_pulse), 32'd1);
        checkOutput("t5_clr_pos", 32'(pos), 32'd0);
        @(negedge CLK);
        checkOutput("t5_pulse_len", 32'(step_pulse), 32'd0);
        repeat (12) @(negedge CLK);
        base = n_step;
        applyStimulus(4'b0000, 20);
        applyStimulus(4'b0010, 20);
        checkOutput("t5_idle_steps", 32'(n_step - base), 32'd0);
        checkOutput("t5_idle_phase", 32'(phase), 32'd1);

        $display("[TB] T6 async reset");
        applyStimulus(4'b0100, 10);
        applyStimulus(4'b1000, 10);
        applyStimulus(4'b0001, 10);
        applyStimulus(4'b0010, 10);
        applyStimulus(4'b0100, 10);
        checkOutput("t6_pre_pos", 32'(pos), 32'd5);
        checkOutput("t6_pre_period", 32'(period), 32'd10);
        {B2, A2, B1, A1} = 4'b1000;
        @(posedge CLK);
        #3 rstn = 1'b0;
        #1;
        checkOutput("t6_rst_phase", 32'(phase), 32'd0);
        checkOutput("t6_rst_valid", 32'(phase_valid), 32'd0);
        checkOutput("t6_rst_dir", 32'(dir), 32'd0);
        checkOutput("t6_rst_pos", 32'(pos), 32'd0);
        checkOutput("t6_rst_period", 32'(period), 32'd0);
        checkOutput("t6_rst_flags", 32'({step_pulse, err_skip, err_pattern}), 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        rstn = 1'b1;
        base = n_step;
        repeat (12) @(negedge CLK);
        checkOutput("t6_post_valid", 32'(phase_valid), 32'd1);
        checkOutput("t6_post_phase", 32'(phase), 32'd3);
        checkOutput("t6_post_steps", 32'(n_step - base), 32'd0);
        applyStimulus(4'b0001, 10);
        checkOutput("t6_step_pos", 32'(pos), 32'd1);
        checkOutput("t6_step_dir", 32'(dir), 32'd1);

        $display("[TB] wrap on fast instance");
        for (int k = 0; k < 32768; k++) begin
            c2 = 4'b0001 << (k % 4);
            @(negedge CLK);
        end
        repeat (5) @(negedge CLK);
        checkOutput("wrap_pos_7fff", 32'(pos2), 32'h00007FFF);
        checkOutput("wrap_steps", 32'(n_step2), 32'd32767);
        checkOutput("wrap_period_fast", 32'(period2), 32'd1);
        c2 = 4'b0001;
        repeat (5) @(negedge CLK);
        checkOutput("wrap_pos_8000", 32'(pos2), 32'h00008000);
        checkOutput("wrap_dir", 32'(dir2), 32'd1);
        checkOutput("wrap_phase", 32'(phase2), 32'd0);
        checkOutput("wrap_valid", 32'(phase_valid2), 32'd1);
        checkOutput("wrap_period", 32'(period2), 32'd6);
        checkOutput("wrap_errs", 32'({err_skip2, err_pattern2}), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
